// File: rtl/vx_issue_sched_pkg.sv
// Shared execute-unit encodings and widths for the warp issue scheduler.
// Latency: n/a (constants only).
// Backpressure: n/a.
package vx_issue_sched_pkg;

  // Execute unit selected by a decoded instruction; the value doubles as the
  // bit index into the unit_ready vector.
  typedef enum logic [2:0] {
    EX_ALU = 3'd0,
    EX_LSU = 3'd1,
    EX_CSR = 3'd2,
    EX_FPU = 3'd3,
    EX_GPU = 3'd4
  } ex_type_e;

  // Number of execute units, i.e. width of unit_ready.
  localparam int EX_UNITS = int'(EX_GPU) + 1;

  // Width of the scheduler stall performance counter.
  localparam int PERF_W = 44;

endpackage

// File: rtl/vx_issue_sched_rr_picker.sv
// Round-robin picker: first set request bit scanning upward from ptr+1, modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own slot state.
//
// Ports:
//   req     - request vector, one bit per requester
//   ptr     - index of the most recent winner (scan starts just above it)
//   gnt     - one-hot grant, zero when no request is set
//   gnt_idx - index of the granted requester (0 when none)
//   gnt_vld - at least one request was set
module vx_issue_sched_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  // The scan visits ptr+1 .. ptr+N, so the previous winner is considered last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!gnt_vld && req[IDX_W'((int'(ptr) + i) % N)]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'((int'(ptr) + i) % N);
        gnt[IDX_W'((int'(ptr) + i) % N)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_issue_sched.sv
// Warp issue scheduler: picks one eligible buffer head per cycle into a registered issue slot.
// Latency: 1 cycle from grant (req_ready strobe) to issue_valid.
// Backpressure: slot holds while issue_valid & !issue_ready; no grant is made until it frees.
//
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   req_valid          - per-warp: decoded instruction at buffer head
//   req_ex_type        - per-warp execute unit of the head, EX_BITS each, warp 0 in the LSBs
//   sb_ready           - per-warp: scoreboard reports no hazard
//   unit_ready         - per-unit: execute unit can accept (bit index = ex_type)
//   req_ready          - one-hot dequeue strobe to the granted warp (combinational)
//   issue_valid/wid/ex_type - registered issue slot
//   issue_ready        - downstream consumes the issue slot
//   perf_sched_stalls  - cycles with a request pending but no grant
module vx_issue_sched
  import vx_issue_sched_pkg::*;
#(
  parameter int NUM_WARPS    = 4,
  parameter int EX_BITS      = 3,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_WARPS-1:0]          req_valid,
  input  logic [NUM_WARPS*EX_BITS-1:0]  req_ex_type,
  input  logic [NUM_WARPS-1:0]          sb_ready,
  input  logic [EX_UNITS-1:0]           unit_ready,
  output logic [NUM_WARPS-1:0]          req_ready,
  output logic                          issue_valid,
  output logic [$clog2(NUM_WARPS)-1:0]  issue_wid,
  output logic [EX_BITS-1:0]            issue_ex_type,
  input  logic                          issue_ready,
  output logic [PERF_W-1:0]             perf_sched_stalls
);

  localparam int WID_W = $clog2(NUM_WARPS);
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  logic [WID_W-1:0]     rr_ptr;
  logic [AGE_W-1:0]     age [NUM_WARPS];

  logic [NUM_WARPS-1:0] eligible;
  logic [NUM_WARPS-1:0] starved;
  logic [NUM_WARPS-1:0] starve_oh;
  logic [NUM_WARPS-1:0] rr_gnt;
  logic [NUM_WARPS-1:0] gnt_oh;
  logic [WID_W-1:0]     starve_idx;
  logic [WID_W-1:0]     rr_idx;
  logic [WID_W-1:0]     gnt_wid;
  logic [EX_BITS-1:0]   gnt_ex;
  logic                 starve_vld;
  logic                 rr_vld;
  logic                 slot_free;
  logic                 grant;

  // Eligibility: matching the head's ex_type against each real unit index
  // means an out-of-range ex_type simply never finds a ready unit.
  always_comb begin
    eligible = '0;
    starved  = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      for (int u = 0; u < EX_UNITS; u++) begin
        if (req_valid[w] && sb_ready[w] && unit_ready[u] &&
            (32'(req_ex_type[w*EX_BITS +: EX_BITS]) == u)) begin
          eligible[w] = 1'b1;
        end
      end
      starved[w] = eligible[w] && (32'(age[w]) == STARVE_LIMIT);
    end
  end

  // Lowest-index starved warp: scan downward so the last hit wins.
  always_comb begin
    starve_vld = 1'b0;
    starve_idx = '0;
    starve_oh  = '0;
    for (int w = NUM_WARPS - 1; w >= 0; w--) begin
      if (starved[w]) begin
        starve_vld = 1'b1;
        starve_idx = WID_W'(w);
        starve_oh  = '0;
        starve_oh[w] = 1'b1;
      end
    end
  end

  vx_issue_sched_rr_picker #(
    .N     (NUM_WARPS),
    .IDX_W (WID_W)
  ) u_rr_picker (
    .req     (eligible),
    .ptr     (rr_ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

  assign slot_free = !issue_valid || issue_ready;
  // A starved warp is always eligible, so rr_vld covers both grant sources.
  assign grant     = slot_free && rr_vld && !reset;
  assign gnt_wid   = starve_vld ? starve_idx : rr_idx;
  assign gnt_oh    = grant ? (starve_vld ? starve_oh : rr_gnt) : '0;
  assign req_ready = gnt_oh;

  always_comb begin
    gnt_ex = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (WID_W'(w) == gnt_wid) begin
        gnt_ex = req_ex_type[w*EX_BITS +: EX_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_valid       <= 1'b0;
      issue_wid         <= '0;
      issue_ex_type     <= '0;
      rr_ptr            <= WID_W'(NUM_WARPS - 1);
      perf_sched_stalls <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        age[w] <= '0;
      end
    end else begin
      if (grant) begin
        issue_valid   <= 1'b1;
        issue_wid     <= gnt_wid;
        issue_ex_type <= gnt_ex;
        rr_ptr        <= gnt_wid;
      end else if (issue_ready) begin
        issue_valid   <= 1'b0;
      end

      if ((|req_valid) && !grant) begin
        perf_sched_stalls <= perf_sched_stalls + PERF_W'(1);
      end

      // Age counts consecutive eligible-but-passed-over cycles, saturating.
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (gnt_oh[w] || !eligible[w]) begin
          age[w] <= '0;
        end else if (32'(age[w]) != STARVE_LIMIT) begin
          age[w] <= age[w] + AGE_W'(1);
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_req_ready_onehot0 : assert property (@(posedge clk) $onehot0(req_ready));
  a_grant_ex_in_range : assert property (@(posedge clk) disable iff (reset)
                                         grant |-> (32'(gnt_ex) < EX_UNITS));
`endif

endmodule
